// File: rtl/gcd_bus_master.sv
// Register-bus initiator for the GPIO/GCD peripheral: loads operands, starts it,
// waits for busy to rise and fall, reads back W and returns it on a result port.
module gcd_bus_master #(
  parameter logic [15:0] ADDR_A1    = 16'h0100,
  parameter logic [15:0] ADDR_A2    = 16'h0108,
  parameter logic [15:0] ADDR_CTRL  = 16'h00F0,
  parameter logic [15:0] ADDR_S     = 16'h00F8,
  parameter logic [15:0] ADDR_W     = 16'h0120,
  parameter int unsigned BUSY_BIT   = 3,
  parameter int unsigned ARM_LIMIT  = 4,
  parameter int unsigned POLL_LIMIT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_a,
  input  logic [31:0] job_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in
);

  typedef enum logic [3:0] {
    IDLE, WR_A1, WR_A2, WR_GO, ARM_RD, ARM_CHK,
    WR_STOP, POLL_RD, POLL_CHK, RD_W, RD_CAP, RESP
  } state_t;

  localparam logic [15:0] ARM_MAX  = 16'(ARM_LIMIT);
  localparam logic [15:0] POLL_MAX = 16'(POLL_LIMIT);

  state_t      state;
  logic [31:0] op_b;
  logic [15:0] arm_cnt;
  logic [15:0] poll_cnt;
  logic        busy;

  assign busy = sdata_in[BUSY_BIT];

  // Outputs are loaded on the edge that enters a state, so each strobe is high
  // during exactly the cycle its state is active. Operand A goes straight into
  // sdata_out on acceptance; only B needs holding for the second write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      job_ready <= 1'b1;
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      res_data  <= '0;
      saddress  <= '0;
      srd       <= 1'b0;
      swr       <= 1'b0;
      sdata_out <= '0;
      op_b      <= '0;
      arm_cnt   <= '0;
      poll_cnt  <= '0;
    end else begin
      srd <= 1'b0;
      swr <= 1'b0;
      case (state)
        IDLE: begin
          if (job_valid) begin
            job_ready <= 1'b0;
            op_b      <= job_b;
            arm_cnt   <= '0;
            poll_cnt  <= '0;
            if (job_a == '0 || job_b == '0) begin
              state     <= RESP;
              res_valid <= 1'b1;
              res_err   <= 1'b1;
              res_data  <= '0;
            end else begin
              state     <= WR_A1;
              swr       <= 1'b1;
              saddress  <= ADDR_A1;
              sdata_out <= job_a;
            end
          end
        end
        WR_A1: begin
          state     <= WR_A2;
          swr       <= 1'b1;
          saddress  <= ADDR_A2;
          sdata_out <= op_b;
        end
        WR_A2: begin
          state     <= WR_GO;
          swr       <= 1'b1;
          saddress  <= ADDR_CTRL;
          sdata_out <= 32'd1;
        end
        WR_GO: begin
          state    <= ARM_RD;
          srd      <= 1'b1;
          saddress <= ADDR_S;
        end
        ARM_RD: state <= ARM_CHK;
        ARM_CHK: begin
          // An unseen busy pulse after the retry budget means it already finished.
          if (!busy && arm_cnt < ARM_MAX) begin
            arm_cnt  <= arm_cnt + 16'd1;
            state    <= ARM_RD;
            srd      <= 1'b1;
            saddress <= ADDR_S;
          end else begin
            state     <= WR_STOP;
            swr       <= 1'b1;
            saddress  <= ADDR_CTRL;
            sdata_out <= '0;
          end
        end
        WR_STOP: begin
          state    <= POLL_RD;
          srd      <= 1'b1;
          saddress <= ADDR_S;
        end
        POLL_RD: state <= POLL_CHK;
        POLL_CHK: begin
          if (!busy) begin
            state    <= RD_W;
            srd      <= 1'b1;
            saddress <= ADDR_W;
          end else if (poll_cnt < POLL_MAX) begin
            poll_cnt <= poll_cnt + 16'd1;
            state    <= POLL_RD;
            srd      <= 1'b1;
            saddress <= ADDR_S;
          end else begin
            state     <= RESP;
            res_valid <= 1'b1;
            res_err   <= 1'b1;
            res_data  <= '0;
          end
        end
        RD_W: state <= RD_CAP;
        RD_CAP: begin
          state     <= RESP;
          res_valid <= 1'b1;
          res_err   <= 1'b0;
          res_data  <= sdata_in;
        end
        RESP: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            job_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
          job_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_bus_master.sv
// Bench for gcd_bus_master: table of GCD jobs against a peripheral model with a
// configurable busy window, plus back-to-back stall and mid-poll reset sequences.
module tb_gcd_bus_master;

  localparam logic [15:0] ADDR_A1   = 16'h0100;
  localparam logic [15:0] ADDR_A2   = 16'h0108;
  localparam logic [15:0] ADDR_CTRL = 16'h00F0;
  localparam logic [15:0] ADDR_S    = 16'h00F8;
  localparam logic [15:0] ADDR_W    = 16'h0120;
  localparam int STUCK = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [31:0] job_a = '0;
  logic [31:0] job_b = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_err;
  logic [15:0] saddress;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_out;
  logic [31:0] sdata_in = '0;

  gcd_bus_master #(.POLL_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready), .job_a(job_a), .job_b(job_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .saddress(saddress), .srd(srd), .swr(swr), .sdata_out(sdata_out), .sdata_in(sdata_in)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- peripheral model ----------------
  function automatic logic [31:0] gcd_f(input logic [31:0] x0, input logic [31:0] y0);
    logic [31:0] x, y, t;
    x = x0; y = y0;
    while (y != 0) begin t = y; y = x % y; x = t; end
    return x;
  endfunction

  int          m_win = 3;
  int          m_cnt = 0;
  logic        m_stuck = 1'b0;
  logic [31:0] m_a1 = '0;
  logic [31:0] m_a2 = '0;
  logic        m_busy;
  assign m_busy = m_stuck || (m_cnt != 0);

  always @(posedge clk) begin
    if (swr && saddress == ADDR_A1) m_a1 <= sdata_out;
    if (swr && saddress == ADDR_A2) m_a2 <= sdata_out;
    if (swr && saddress == ADDR_CTRL && sdata_out == 32'd1) begin
      m_cnt   <= m_win;
      m_stuck <= (m_win == STUCK);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
    if (srd) begin
      if (saddress == ADDR_S)      sdata_in <= {28'd0, m_busy, 3'd0};
      else if (saddress == ADDR_W) sdata_in <= gcd_f(m_a1, m_a2);
      else                         sdata_in <= 32'hDEAD_BEEF;
    end
  end

  // ---------------- bus monitor ----------------
  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
  } bus_t;

  bus_t blog[$];
  logic both_seen = 1'b0;

  always @(posedge clk) begin
    if (!reset && (srd || swr)) begin
      bus_t e;
      e.wr = swr; e.addr = saddress; e.data = sdata_out;
      blog.push_back(e);
      if (srd && swr) both_seen <= 1'b1;
    end
  end

  function automatic bit has_stop();
    foreach (blog[i]) if (blog[i].wr && blog[i].addr == ADDR_CTRL && blog[i].data == 0) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          win;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_arm;
    int          exp_poll;
    int          exp_wrd;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input int idx, input vec_t v);
    int k, wr_cnt, arm, poll, wrd, phase;
    bit got, seq_ok, zero;
    string p;
    p = $sformatf("v%0d", idx);
    zero = (v.a == 0 || v.b == 0);
    blog.delete();
    m_win = v.win;
    @(negedge clk);
    job_a = v.a; job_b = v.b; job_valid = 1'b1;
    k = 0;
    while (!job_ready && k < 50) begin @(negedge clk); k++; end
    chk({p, "_ready"}, job_ready, 1);
    @(posedge clk);
    k = 0; got = 0;
    while (!got && k < 200) begin
      @(negedge clk); k++; job_valid = 1'b0;
      if (res_valid) got = 1;
    end
    chk({p, "_latency"}, k, v.exp_lat);
    chk({p, "_data"}, res_data, v.exp_data);
    chk({p, "_err"}, res_err, v.exp_err);
    chk({p, "_jobready_busy"}, job_ready, 0);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk({p, "_valid_drop"}, res_valid, 0);
    chk({p, "_ready_back"}, job_ready, 1);
    wr_cnt = 0; arm = 0; poll = 0; wrd = 0; phase = 0; seq_ok = 1;
    foreach (blog[i]) begin
      if (blog[i].wr) begin
        wr_cnt++;
        if (i == 0)      seq_ok &= (blog[i].addr == ADDR_A1 && blog[i].data == v.a);
        else if (i == 1) seq_ok &= (blog[i].addr == ADDR_A2 && blog[i].data == v.b);
        else if (i == 2) seq_ok &= (blog[i].addr == ADDR_CTRL && blog[i].data == 32'd1);
        else if (blog[i].addr == ADDR_CTRL && blog[i].data == 0 && phase == 0) phase = 1;
        else seq_ok = 0;
      end else if (blog[i].addr == ADDR_S && i > 2) begin
        if (phase == 0) arm++; else poll++;
      end else if (blog[i].addr == ADDR_W && phase == 1 && i == blog.size() - 1) begin
        wrd++;
      end else begin
        seq_ok = 0;
      end
    end
    chk({p, "_writes"}, wr_cnt, zero ? 0 : 4);
    chk({p, "_arm_reads"}, arm, v.exp_arm);
    chk({p, "_poll_reads"}, poll, v.exp_poll);
    chk({p, "_w_reads"}, wrd, v.exp_wrd);
    chk({p, "_bus_order"}, seq_ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit got;
    //          a             b    win    data  err lat arm poll wrd
    vecs[0] = '{32'd48,       32'd18, 3,     32'd6,  1'b0, 11, 1, 1, 1};
    vecs[1] = '{32'd0,        32'd7,  3,     32'd0,  1'b1, 1,  0, 0, 0};
    vecs[2] = '{32'd7,        32'd0,  3,     32'd0,  1'b1, 1,  0, 0, 0};
    vecs[3] = '{32'd5,        32'd5,  0,     32'd5,  1'b0, 19, 5, 1, 1};
    vecs[4] = '{32'd100,      32'd75, STUCK, 32'd0,  1'b1, 25, 1, 9, 0};
    vecs[5] = '{32'd84,       32'd36, 8,     32'd12, 1'b0, 17, 1, 4, 1};
    vecs[6] = '{32'hFFFFFFFF, 32'd3,  3,     32'd3,  1'b0, 11, 1, 1, 1};
    vecs[7] = '{32'd1,        32'd1,  3,     32'd1,  1'b0, 11, 1, 1, 1};

    repeat (3) @(negedge clk);
    chk("reset_job_ready", job_ready, 1);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_strobes", {srd, swr}, 0);
    chk("reset_saddress", saddress, 0);
    chk("reset_sdata_out", sdata_out, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Back-to-back: (12,8) then (17,5) already offered while the first result stalls.
    m_win = 3;
    @(negedge clk);
    job_a = 32'd12; job_b = 32'd8; job_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    job_a = 32'd17; job_b = 32'd5;
    k = 0; got = 0;
    while (!got && k < 100) begin
      if (res_valid) got = 1; else begin @(negedge clk); k++; end
    end
    chk("b2b_first_valid", res_valid, 1);
    k = blog.size();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("b2b_stall%0d_valid", c), res_valid, 1);
      chk($sformatf("b2b_stall%0d_data", c), res_data, 32'd4);
      chk($sformatf("b2b_stall%0d_noready", c), job_ready, 0);
      @(negedge clk);
    end
    chk("b2b_no_bus_during_stall", blog.size(), k);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("b2b_after_R_valid", res_valid, 0);
    chk("b2b_after_R_ready", job_ready, 1);
    chk("b2b_after_R_swr", swr, 0);
    @(negedge clk);
    job_valid = 1'b0;
    chk("b2b_second_swr", swr, 1);
    chk("b2b_second_addr", saddress, ADDR_A1);
    chk("b2b_second_data", sdata_out, 32'd17);
    k = 0;
    while (!res_valid && k < 100) begin @(negedge clk); k++; end
    chk("b2b_second_result", res_data, 32'd1);
    chk("b2b_second_err", res_err, 0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;

    // Reset asserted during the POLL_RD strobe cycle.
    blog.delete();
    m_win = 8;
    @(negedge clk);
    job_a = 32'd48; job_b = 32'd18; job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    k = 0; got = 0;
    while (!got && k < 100) begin
      if (srd && saddress == ADDR_S && has_stop()) got = 1; else begin @(negedge clk); k++; end
    end
    chk("rst_reached_poll", got, 1);
    reset = 1'b1;
    #1;
    chk("rst_srd", srd, 0);
    chk("rst_swr", swr, 0);
    chk("rst_job_ready", job_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_saddress", saddress, 0);
    chk("rst_sdata_out", sdata_out, 0);
    @(negedge clk);
    reset = 1'b0;
    run_vec(8, '{32'd9, 32'd6, 3, 32'd3, 1'b0, 11, 1, 1, 1});

    chk("no_rd_wr_overlap", both_seen, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
